// File: rtl/hitgraph_cac_pkg.sv
// Shared types and sizing helpers for the compare-and-combine pair scheduler.
package hitgraph_cac_pkg;

    localparam int DATA_W_DEFAULT = 32;

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        FLUSH,
        DONE
    } sched_state_e;

    function automatic int credit_w(input int out_credits);
        return $clog2(out_credits + 1);
    endfunction

endpackage

// File: rtl/cac_credit_counter.sv
// Credit counter guarding the downstream buffer: clamps at both ends and flags
// a sticky overflow when a return arrives while already full.
module cac_credit_counter
    import hitgraph_cac_pkg::*;
#(
    parameter int MAX_COUNT = 4,
    parameter int W         = credit_w(MAX_COUNT)
) (
    input  logic clk,
    input  logic rst,
    input  logic inc_i,
    input  logic dec_i,
    output logic nonzero_o,
    output logic overflow_o
);

    logic [W-1:0] count_q, count_d;
    logic         overflow_q, overflow_d;
    logic         full, incOk, decOk;

    // A return while full is dropped, even if a consume lands in the same cycle.
    always_comb begin
        full       = (count_q == W'(MAX_COUNT));
        incOk      = inc_i & ~full;
        decOk      = dec_i & (count_q != '0);
        overflow_d = overflow_q | (inc_i & full);
        count_d    = count_q;
        unique case ({incOk, decOk})
            2'b10:   count_d = count_q + W'(1);
            2'b01:   count_d = count_q - W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q    <= W'(MAX_COUNT);
            overflow_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    assign nonzero_o  = (count_q != '0);
    assign overflow_o = overflow_q;

endmodule

// File: rtl/cac_pair_scheduler.sv
// Pairs consecutive (dest_vid, update) tuples onto the A/B lanes of one CaC
// instance under a downstream credit limit, then drains and signals partition end.
module cac_pair_scheduler
    import hitgraph_cac_pkg::*;
#(
    parameter int DATA_W       = DATA_W_DEFAULT,
    parameter int PIPE_DEPTH   = 3,
    parameter int OUT_CREDITS  = 4,
    parameter int HOLD_TIMEOUT = 4,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_dest_vid,
    input  logic [DATA_W-1:0] in_update,
    input  logic              in_last,
    output logic              issue_valid_a,
    output logic              issue_valid_b,
    output logic [DATA_W-1:0] issue_dest_vid_a,
    output logic [DATA_W-1:0] issue_dest_vid_b,
    output logic [DATA_W-1:0] issue_update_a,
    output logic [DATA_W-1:0] issue_update_b,
    input  logic              credit_return,
    output logic              partition_done,
    output logic              busy,
    output logic [CNT_W-1:0]  issue_count,
    output logic              credit_err
);

    localparam int TMR_W = $clog2(HOLD_TIMEOUT + 1);
    localparam int DRN_W = $clog2(PIPE_DEPTH + 2);

    sched_state_e      state_q, state_d;
    logic [DATA_W-1:0] holdVid_q, holdVid_d, holdUpd_q, holdUpd_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic [DRN_W-1:0]  drain_q, drain_d;
    logic              vaA_q, vaA_d, vaB_q, vaB_d;
    logic [DATA_W-1:0] vidA_q, vidA_d, vidB_q, vidB_d, updA_q, updA_d, updB_q, updB_d;
    logic [CNT_W-1:0]  issueCount_q;
    logic              creditNz, accept;

    assign in_ready = ~rst & ((state_q == IDLE) | (state_q == HOLD)) & creditNz;
    assign accept   = in_valid & in_ready;

    always_comb begin
        state_d   = state_q;
        holdVid_d = holdVid_q;
        holdUpd_d = holdUpd_q;
        timer_d   = timer_q;
        drain_d   = drain_q;
        vaA_d     = 1'b0;
        vaB_d     = 1'b0;
        vidA_d    = '0;
        vidB_d    = '0;
        updA_d    = '0;
        updB_d    = '0;
        unique case (state_q)
            IDLE: begin
                if (accept && in_last) begin
                    vaA_d   = 1'b1;
                    vidA_d  = in_dest_vid;
                    updA_d  = in_update;
                    drain_d = DRN_W'(PIPE_DEPTH + 1);
                    state_d = FLUSH;
                end else if (accept) begin
                    holdVid_d = in_dest_vid;
                    holdUpd_d = in_update;
                    timer_d   = '0;
                    state_d   = HOLD;
                end
            end
            // A partner arriving wins over an expiring timer in the same cycle.
            HOLD: begin
                if (accept) begin
                    vaA_d   = 1'b1;
                    vidA_d  = holdVid_q;
                    updA_d  = holdUpd_q;
                    vaB_d   = 1'b1;
                    vidB_d  = in_dest_vid;
                    updB_d  = in_update;
                    drain_d = DRN_W'(PIPE_DEPTH + 1);
                    state_d = in_last ? FLUSH : IDLE;
                end else if (timer_q >= TMR_W'(HOLD_TIMEOUT - 1)) begin
                    if (creditNz) begin
                        vaA_d   = 1'b1;
                        vidA_d  = holdVid_q;
                        updA_d  = holdUpd_q;
                        state_d = IDLE;
                    end else begin
                        timer_d = TMR_W'(HOLD_TIMEOUT);
                    end
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            FLUSH: begin
                if (drain_q == '0) state_d = DONE;
                else               drain_d = drain_q - DRN_W'(1);
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            holdVid_q <= '0;
            holdUpd_q <= '0;
            timer_q   <= '0;
            drain_q   <= '0;
            vaA_q     <= 1'b0;
            vaB_q     <= 1'b0;
            vidA_q    <= '0;
            vidB_q    <= '0;
            updA_q    <= '0;
            updB_q    <= '0;
        end else begin
            state_q   <= state_d;
            holdVid_q <= holdVid_d;
            holdUpd_q <= holdUpd_d;
            timer_q   <= timer_d;
            drain_q   <= drain_d;
            vaA_q     <= vaA_d;
            vaB_q     <= vaB_d;
            vidA_q    <= vidA_d;
            vidB_q    <= vidB_d;
            updA_q    <= updA_d;
            updB_q    <= updB_d;
        end
    end

    // The count is held through DONE so the partition total is visible alongside the pulse.
    always_ff @(posedge clk) begin
        if (rst || state_q == DONE) begin
            issueCount_q <= '0;
        end else if (vaA_d && issueCount_q != '1) begin
            issueCount_q <= issueCount_q + CNT_W'(1);
        end
    end

    cac_credit_counter #(
        .MAX_COUNT (OUT_CREDITS),
        .W         (credit_w(OUT_CREDITS))
    ) u_credits (
        .clk        (clk),
        .rst        (rst),
        .inc_i      (credit_return),
        .dec_i      (vaA_d),
        .nonzero_o  (creditNz),
        .overflow_o (credit_err)
    );

    assign issue_valid_a    = vaA_q;
    assign issue_valid_b    = vaB_q;
    assign issue_dest_vid_a = vidA_q;
    assign issue_dest_vid_b = vidB_q;
    assign issue_update_a   = updA_q;
    assign issue_update_b   = updB_q;
    assign partition_done   = (state_q == DONE);
    assign busy             = (state_q != IDLE);
    assign issue_count      = issueCount_q;

endmodule

// File: tb/tb_cac_pair_scheduler.sv
// Self-checking bench for cac_pair_scheduler: directed scenarios plus a random
// stream compared every cycle against a queue-based behavioural model.
module tb_cac_pair_scheduler;

    localparam int DATA_W       = 32;
    localparam int PIPE_DEPTH   = 3;
    localparam int OUT_CREDITS  = 4;
    localparam int HOLD_TIMEOUT = 4;
    localparam int CNT_W        = 16;
    localparam int CNT_MAX      = (1 << CNT_W) - 1;

    typedef struct packed {
        logic [DATA_W-1:0] vid;
        logic [DATA_W-1:0] upd;
    } tuple_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic inValid = 1'b0, inLast = 1'b0, creditReturn = 1'b0;
    logic [DATA_W-1:0] inVid = '0, inUpd = '0;
    logic inReady, vaA, vaB, partDone, busy, creditErr;
    logic [DATA_W-1:0] vidA, vidB, updA, updB;
    logic [CNT_W-1:0] issueCount;

    int total = 0;
    int bad = 0;
    bit checkEn = 1'b0;

    // Model state: pending tuples, credits, drain countdown, pulse and counters.
    tuple_t mHold[$];
    int mCredits = OUT_CREDITS, mWaited = 0, mFlushLeft = 0, mCount = 0;
    bit mFlushing = 1'b0, mDone = 1'b0, mErr = 1'b0, mVa = 1'b0, mVb = 1'b0;
    tuple_t mA = '0, mB = '0;

    always #5 clk = ~clk;

    cac_pair_scheduler #(
        .DATA_W(DATA_W), .PIPE_DEPTH(PIPE_DEPTH), .OUT_CREDITS(OUT_CREDITS),
        .HOLD_TIMEOUT(HOLD_TIMEOUT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReady),
        .in_dest_vid(inVid), .in_update(inUpd), .in_last(inLast),
        .issue_valid_a(vaA), .issue_valid_b(vaB),
        .issue_dest_vid_a(vidA), .issue_dest_vid_b(vidB),
        .issue_update_a(updA), .issue_update_b(updB),
        .credit_return(creditReturn), .partition_done(partDone), .busy(busy),
        .issue_count(issueCount), .credit_err(creditErr)
    );

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [DATA_W-1:0] vid, input logic [DATA_W-1:0] upd,
                                 input logic last, input logic ret);
        inValid      = v;
        inVid        = vid;
        inUpd        = upd;
        inLast       = last;
        creditReturn = ret;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic returnCredits(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
            tick();
        end
        idle();
    endtask

    // Edge-by-edge model: tuples queue up until a partner, a last flag or the
    // wait limit releases them; every release spends one credit.
    task automatic modelStep();
        tuple_t lanes[$];
        bit ready, inc, dec;
        ready = !mFlushing && !mDone && mCredits > 0;
        lanes = {};
        if (rst) begin
            mHold = {};
            mCredits = OUT_CREDITS;
            mWaited = 0; mFlushLeft = 0; mCount = 0;
            mFlushing = 0; mDone = 0; mErr = 0;
        end else begin
            if (mDone) begin
                mDone = 0;
                mCount = 0;
            end else if (mFlushing) begin
                if (mFlushLeft == 0) begin mFlushing = 0; mDone = 1; end
                else mFlushLeft--;
            end else if (inValid && ready) begin
                mHold.push_back({inVid, inUpd});
                if (inLast || mHold.size() == 2) begin
                    lanes = mHold;
                    mHold = {};
                end
                if (inLast) begin mFlushing = 1; mFlushLeft = PIPE_DEPTH + 1; end
                mWaited = 0;
            end else if (mHold.size() == 1) begin
                if (mWaited < HOLD_TIMEOUT) mWaited++;
                if (mWaited >= HOLD_TIMEOUT && mCredits > 0) begin
                    lanes = mHold;
                    mHold = {};
                    mWaited = 0;
                end
            end
            inc = creditReturn && mCredits < OUT_CREDITS;
            dec = lanes.size() > 0;
            if (creditReturn && mCredits == OUT_CREDITS) mErr = 1;
            mCredits = mCredits - int'(dec) + int'(inc);
            if (dec && mCount < CNT_MAX) mCount++;
        end
        mVa = lanes.size() > 0;
        mVb = lanes.size() > 1;
        mA  = mVa ? lanes[0] : '0;
        mB  = mVb ? lanes[1] : '0;
    endtask

    always @(posedge clk) modelStep();

    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("in_ready", inReady, !rst && !mFlushing && !mDone && mCredits > 0);
            checkOutput("valid_a", vaA, mVa);
            checkOutput("valid_b", vaB, mVb);
            checkOutput("vid_a", vidA, mA.vid);
            checkOutput("upd_a", updA, mA.upd);
            checkOutput("vid_b", vidB, mB.vid);
            checkOutput("upd_b", updB, mB.upd);
            checkOutput("partition_done", partDone, mDone);
            checkOutput("busy", busy, mHold.size() > 0 || mFlushing || mDone);
            checkOutput("issue_count", issueCount, mCount);
            checkOutput("credit_err", creditErr, mErr);
        end
    end

    initial begin
        int n, accepted, issues, density;
        bit wasReady, found;

        // Reset
        idle();
        tick();
        checkEn = 1'b1;
        checkOutput("reset_in_ready", inReady, 0);
        checkOutput("reset_valid_a", vaA, 0);
        checkOutput("reset_count", issueCount, 0);
        tick();
        rst = 1'b0;
        #1;
        checkOutput("post_reset_in_ready", inReady, 1);

        // Pairing and partition completion
        applyStimulus(1, 5, 10, 0, 0);  tick();
        applyStimulus(1, 3, 7, 0, 0);   tick();
        checkOutput("pair1_valid_b", vaB, 1);
        checkOutput("pair1_a", {vidA, updA}, {32'd5, 32'd10});
        checkOutput("pair1_b", {vidB, updB}, {32'd3, 32'd7});
        applyStimulus(1, 9, 1, 1, 0);   tick();
        checkOutput("pair2_a", {vidA, updA}, {32'd9, 32'd1});
        checkOutput("pair2_valid_b", vaB, 0);
        idle();
        n = 0;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (partDone) begin
                n = c;
                checkOutput("done_issue_count", issueCount, 2);
                break;
            end
        end
        checkOutput("done_delay", n, PIPE_DEPTH + 2);
        tick();
        checkOutput("count_cleared", issueCount, 0);
        returnCredits(2);

        // Lone tuple times out
        applyStimulus(1, 4, 2, 0, 0);   tick();
        idle();
        n = 0;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (vaA) begin
                n = c;
                checkOutput("lone_a", {vidA, updA}, {32'd4, 32'd2});
                checkOutput("lone_valid_b", vaB, 0);
                break;
            end
        end
        checkOutput("hold_timeout_delay", n, HOLD_TIMEOUT);
        returnCredits(1);

        // Credit exhaustion, then one return releases exactly one issue
        accepted = 0; issues = 0;
        for (int c = 0; c < 24; c++) begin
            if (accepted < 10) applyStimulus(1, 100 + accepted, accepted, 0, 0);
            else idle();
            wasReady = inReady;
            tick();
            if (wasReady && accepted < 10) accepted++;
            if (vaA) issues++;
        end
        checkOutput("exhaust_accepted", accepted, 8);
        checkOutput("exhaust_issues", issues, 4);
        checkOutput("exhaust_in_ready", inReady, 0);
        issues = 0;
        for (int c = 0; c < 16; c++) begin
            if (accepted < 10) applyStimulus(1, 100 + accepted, accepted, 0, c == 0);
            else idle();
            wasReady = inReady;
            tick();
            if (wasReady && accepted < 10) accepted++;
            if (vaA) issues++;
        end
        checkOutput("one_return_issues", issues, 1);
        checkOutput("one_return_accepted", accepted, 10);

        // Issue and return in the same cycle at one credit
        returnCredits(1);
        applyStimulus(1, 11, 22, 0, 0); tick();
        applyStimulus(1, 33, 44, 0, 1); tick();
        idle();
        checkOutput("simul_valid_b", vaB, 1);
        checkOutput("simul_in_ready", inReady, 1);
        returnCredits(3);

        // Return while already full
        checkOutput("pre_err", creditErr, 0);
        returnCredits(1);
        checkOutput("full_return_err", creditErr, 1);
        tick(); tick(); tick();
        checkOutput("err_sticky", creditErr, 1);
        checkOutput("full_in_ready", inReady, 1);

        // Reset while a tuple is held
        applyStimulus(1, 7, 3, 0, 0);   tick();
        idle();
        rst = 1'b1;
        tick();
        checkOutput("rst_hold_valid_a", vaA, 0);
        checkOutput("rst_hold_done", partDone, 0);
        checkOutput("rst_hold_in_ready", inReady, 0);
        checkOutput("rst_err_cleared", creditErr, 0);
        rst = 1'b0;
        tick();
        checkOutput("after_rst_in_ready", inReady, 1);
        checkOutput("after_rst_valid_a", vaA, 0);
        applyStimulus(1, 1, 1, 0, 0);   tick();
        checkOutput("after_rst_no_issue", vaA, 0);
        applyStimulus(1, 2, 2, 0, 0);   tick();
        checkOutput("after_rst_pair", {vidA, vidB}, {32'd1, 32'd2});
        idle();
        tick();

        // Random traffic
        density = 2;
        for (int c = 0; c < 1500; c++) begin
            if (c % 64 == 0) density = $urandom_range(1, 4);
            rst = ($urandom_range(0, 299) == 0);
            applyStimulus(int'($urandom_range(0, 3)) < density, $urandom, $urandom,
                          $urandom_range(0, 7) == 0,
                          (mCredits < OUT_CREDITS) && ($urandom_range(0, 2) == 0));
            tick();
        end
        rst = 1'b0;
        idle();
        for (int c = 0; c < 20; c++) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
